ms_alu_sequencer: RTL and testbench

//  Control-side initiator for the shared-bus datapath: decodes one instruction word and sequences the
//  ALU load strobes (Ain, Gin, Gout, ALUControl), the bus source select and the register write enables.

---
 rtl/ms_ctrl_pkg.sv | 79 +++++++
 rtl/ms_instr_decode.sv | 42 ++++
 rtl/ms_alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_ms_alu_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_ctrl_pkg.sv
// Purpose : shared types and encodings for the shared-bus ALU sequencer and its ALU.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t        sequencer states
//   opcode_t       instruction opcodes (IR[9:7])
//   opclass_t      how an opcode is sequenced (move / unary ALU / binary ALU)
//   ALU_*          ALUControl encodings, shared with the ALU itself
//   BUS_*_OFS      bus source codes above the register range (added to NREG)
//   op_to_aluctrl  opcode -> ALUControl
//   op_to_class    opcode -> opclass_t
package ms_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_MV   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_MOV  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_INV  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } opcode_t;

  // MOVE: single write-back cycle; UNARY: skips the A load; BINARY: full T1..T4.
  typedef enum logic [1:0] {
    CLS_MOVE   = 2'd0,
    CLS_UNARY  = 2'd1,
    CLS_BINARY = 2'd2
  } opclass_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_INV = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // Bus source codes: 0..NREG-1 select a register; these offsets sit above that range.
  localparam int BUS_DIN_OFS  = 0;
  localparam int BUS_ALUQ_OFS = 1;

  function automatic logic [2:0] op_to_aluctrl(input opcode_t op);
    logic [2:0] c;
    c = ALU_ADD;
    case (op)
      OP_ADD:  c = ALU_ADD;
      OP_SUB:  c = ALU_SUB;
      OP_INV:  c = ALU_INV;
      OP_AND:  c = ALU_AND;
      OP_OR:   c = ALU_OR;
      OP_XOR:  c = ALU_XOR;
      default: c = ALU_ADD;  // LOAD/MOV never drive the ALU
    endcase
    return c;
  endfunction

  function automatic opclass_t op_to_class(input opcode_t op);
    opclass_t k;
    k = CLS_BINARY;
    case (op)
      OP_LOAD, OP_MOV: k = CLS_MOVE;
      OP_INV:          k = CLS_UNARY;
      default:         k = CLS_BINARY;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ms_instr_decode.sv
// Purpose : combinational instruction decode: IR -> {opcode class, LOAD flag, Rx, Ry, ALUControl}.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   ir       in   WIDTH       instruction word: [W-1:W-3] opcode, then Rx, then Ry, rest reserved
//   opclass  out  2           opclass_t encoding
//   is_load  out  1           opcode is LOAD (bus source is Din rather than Ry)
//   rx, ry   out  REGSEL_W    register fields
//   aluctrl  out  3           ALUControl for the opcode
module ms_instr_decode
  import ms_ctrl_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int REGSEL_W = 2
) (
  input  logic [WIDTH-1:0]    ir,
  output logic [1:0]          opclass,
  output logic                is_load,
  output logic [REGSEL_W-1:0] rx,
  output logic [REGSEL_W-1:0] ry,
  output logic [2:0]          aluctrl
);

  localparam int OP_LSB = WIDTH - 3;
  localparam int RX_LSB = OP_LSB - REGSEL_W;
  localparam int RY_LSB = RX_LSB - REGSEL_W;

  opcode_t opcode;

  assign opcode  = opcode_t'(ir[WIDTH-1:OP_LSB]);
  assign rx      = ir[OP_LSB-1:RX_LSB];
  assign ry      = ir[RX_LSB-1:RY_LSB];
  assign opclass = op_to_class(opcode);
  assign is_load = (opcode == OP_LOAD);
  assign aluctrl = op_to_aluctrl(opcode);

  // Low reserved bits carry no meaning; folded here only so they are visibly consumed.
  logic unused_rsvd;
  assign unused_rsvd = ^ir[RY_LSB-1:0];

endmodule

// File: rtl/ms_alu_sequencer.sv
// Purpose : decodes one instruction and sequences ALU strobes, bus select and register writes.
// Latency : busy for 4 cycles (binary ALU op), 3 (INV), 1 (LOAD/MOV); >=1 IDLE cycle between ops.
// Backpressure: Run is only sampled in IDLE; Run/Instr are ignored while Busy.
//
// Ports:
//   CLKb        in   1            clock, all state changes on the falling edge
//   Reset       in   1            asynchronous active-high reset
//   Run         in   1            start request, sampled in IDLE
//   Instr       in   WIDTH        instruction, captured into IR when Run is accepted
//   Busy        out  1            state != IDLE
//   Done        out  1            high in the write-back cycle
//   BusSel      out  REGSEL_W+1   0..NREG-1 register, NREG Din, NREG+1 ALU Q
//   Rin         out  NREG         one-hot register write enable
//   Ain/Gin/Gout out 1            ALU A load / G load / Q load
//   ALUControl  out  3            ALU operation
module ms_alu_sequencer
  import ms_ctrl_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int REGSEL_W = 2
) (
  input  logic                   CLKb,
  input  logic                   Reset,
  input  logic                   Run,
  input  logic [WIDTH-1:0]       Instr,
  output logic                   Busy,
  output logic                   Done,
  output logic [REGSEL_W:0]      BusSel,
  output logic [2**REGSEL_W-1:0] Rin,
  output logic                   Ain,
  output logic                   Gin,
  output logic                   Gout,
  output logic [2:0]             ALUControl
);

  localparam int NREG = 2**REGSEL_W;
  localparam logic [REGSEL_W:0] BUS_DIN  = (REGSEL_W+1)'(NREG + BUS_DIN_OFS);
  localparam logic [REGSEL_W:0] BUS_ALUQ = (REGSEL_W+1)'(NREG + BUS_ALUQ_OFS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q;

  // A single decoder serves both uses: in IDLE it looks at the incoming Instr to pick the
  // first state (outputs are all forced to 0 there, so nothing else sees it); in every other
  // state it looks at the captured IR, which keeps the instruction stable for its duration.
  logic [WIDTH-1:0]    dec_in;
  logic [1:0]          dec_class;
  logic                dec_is_load;
  logic [REGSEL_W-1:0] dec_rx;
  logic [REGSEL_W-1:0] dec_ry;
  logic [2:0]          dec_aluctrl;

  assign dec_in = (state_q == S_IDLE) ? Instr : ir_q;

  ms_instr_decode #(
    .WIDTH    (WIDTH),
    .REGSEL_W (REGSEL_W)
  ) u_decode (
    .ir      (dec_in),
    .opclass (dec_class),
    .is_load (dec_is_load),
    .rx      (dec_rx),
    .ry      (dec_ry),
    .aluctrl (dec_aluctrl)
  );

  // State and IR registers. Reset aborts any instruction in flight; the ALU's own
  // partial state is not touched.
  always_ff @(negedge CLKb or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && Run) begin
        ir_q <= Instr;
      end
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_d    = state_q;
    Busy       = 1'b0;
    Done       = 1'b0;
    BusSel     = '0;
    Rin        = '0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    ALUControl = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (Run) begin
          case (opclass_t'(dec_class))
            CLS_MOVE:  state_d = S_MV;
            CLS_UNARY: state_d = S_T2;  // INV has no A operand
            default:   state_d = S_T1;
          endcase
        end
      end

      S_T1: begin
        Busy    = 1'b1;
        BusSel  = {1'b0, dec_rx};
        Ain     = 1'b1;
        state_d = S_T2;
      end

      S_T2: begin
        Busy       = 1'b1;
        BusSel     = {1'b0, dec_ry};
        Gin        = 1'b1;
        ALUControl = dec_aluctrl;
        state_d    = S_T3;
      end

      S_T3: begin
        Busy       = 1'b1;
        Gout       = 1'b1;
        ALUControl = dec_aluctrl;  // held so the ALU sees a steady op while G moves to Q
        state_d    = S_T4;
      end

      S_T4: begin
        Busy        = 1'b1;
        BusSel      = BUS_ALUQ;
        Rin[dec_rx] = 1'b1;
        Done        = 1'b1;
        state_d     = S_IDLE;
      end

      S_MV: begin
        Busy        = 1'b1;
        BusSel      = dec_is_load ? BUS_DIN : {1'b0, dec_ry};
        Rin[dec_rx] = 1'b1;
        Done        = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ms_alu_sequencer.sv
// Purpose : directed bench for ms_alu_sequencer with a datapath/ALU model and write-back scoreboard.
// Latency : checks every busy cycle of each instruction plus the IDLE cycle after it.
// Backpressure: n/a.
module tb_ms_alu_sequencer;

  logic       CLKb = 1'b1;
  logic       Reset;
  logic       Run = 1'b0;
  logic [9:0] Instr = '0;
  logic       Busy, Done;
  logic [2:0] BusSel;
  logic [3:0] Rin;
  logic       Ain, Gin, Gout;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;

  ms_alu_sequencer #(.WIDTH(10), .REGSEL_W(2)) dut (
    .CLKb       (CLKb),
    .Reset      (Reset),
    .Run        (Run),
    .Instr      (Instr),
    .Busy       (Busy),
    .Done       (Done),
    .BusSel     (BusSel),
    .Rin        (Rin),
    .Ain        (Ain),
    .Gin        (Gin),
    .Gout       (Gout),
    .ALUControl (ALUControl)
  );

  always #5 CLKb = ~CLKb;

  // ---------------- datapath model driven by the DUT strobes ----------------
  logic [9:0] R [4];
  logic [9:0] A, G, Q, Din;
  logic [9:0] bus;
  logic [9:0] gold [4];
  logic [13:0] sb [$];       // {one-hot Rin, written value}
  logic [14:0] cyc_q [$];    // expected output vectors, one per busy cycle

  assign bus = (BusSel < 3'd4) ? R[BusSel[1:0]] : (BusSel == 3'd4) ? Din : Q;

  function automatic logic [9:0] alu(input logic [2:0] c, input logic [9:0] a, input logic [9:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return -b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      default: return 10'h000;
    endcase
  endfunction

  always @(negedge CLKb) begin
    logic [13:0] e;
    if (Ain) A <= bus;
    if (Gin) G <= alu(ALUControl, A, bus);
    if (Gout) Q <= G;
    for (int i = 0; i < 4; i++) if (Rin[i]) R[i] <= bus;
    if (Done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL wb_underflow: observed write rin=%b val=%h with nothing expected", Rin, bus);
      end else begin
        e = sb.pop_front();
        assert ({Rin, bus} === e) else begin
          errors++;
          $error("FAIL wb: observed rin=%b val=%h required rin=%b val=%h", Rin, bus, e[13:10], e[9:0]);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [14:0] mk(input logic busy, input logic done, input logic [2:0] bs,
                                     input logic [3:0] rin, input logic ain, input logic gin,
                                     input logic gout, input logic [2:0] aluc);
    return {busy, done, bs, rin, ain, gin, gout, aluc};
  endfunction

  function automatic logic [9:0] ins(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry);
    return {op, rx, ry, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {Busy, Done, BusSel, Rin, Ain, Gin, Gout, ALUControl};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b required %b (busy,done,bussel,rin,ain,gin,gout,aluctrl)", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs straight from the instruction's semantics.
  task automatic build(input logic [9:0] instr);
    logic [2:0] op, aluc;
    logic [1:0] rx, ry;
    logic [3:0] oh;
    op = instr[9:7]; rx = instr[6:5]; ry = instr[4:3];
    oh = 4'b0001 << rx;
    case (op)
      3'd2: aluc = 3'b000;
      3'd3: aluc = 3'b001;
      3'd4: aluc = 3'b010;
      3'd5: aluc = 3'b011;
      3'd6: aluc = 3'b100;
      3'd7: aluc = 3'b101;
      default: aluc = 3'b000;
    endcase
    if (op == 3'd0) begin
      cyc_q.push_back(mk(1, 1, 3'd4, oh, 0, 0, 0, 3'b000));
    end else if (op == 3'd1) begin
      cyc_q.push_back(mk(1, 1, {1'b0, ry}, oh, 0, 0, 0, 3'b000));
    end else begin
      if (op != 3'd4) cyc_q.push_back(mk(1, 0, {1'b0, rx}, 4'b0, 1, 0, 0, 3'b000));
      cyc_q.push_back(mk(1, 0, {1'b0, ry}, 4'b0, 0, 1, 0, aluc));
      cyc_q.push_back(mk(1, 0, 3'd0, 4'b0, 0, 0, 1, aluc));
      cyc_q.push_back(mk(1, 1, 3'd5, oh, 0, 0, 0, 3'b000));
    end
  endtask

  // Drive an instruction and record its architectural result in the scoreboard.
  task automatic issue(input logic [9:0] instr, input logic [9:0] din);
    logic [2:0] op;
    logic [1:0] rx, ry;
    logic [9:0] v;
    op = instr[9:7]; rx = instr[6:5]; ry = instr[4:3];
    case (op)
      3'd0: v = din;
      3'd1: v = gold[ry];
      3'd2: v = gold[rx] + gold[ry];
      3'd3: v = gold[rx] - gold[ry];
      3'd4: v = -gold[ry];
      3'd5: v = gold[rx] & gold[ry];
      3'd6: v = gold[rx] | gold[ry];
      default: v = gold[rx] ^ gold[ry];
    endcase
    gold[rx] = v;
    sb.push_back({4'b0001 << rx, v});
    Run = 1'b1; Instr = instr; Din = din;
  endtask

  task automatic run_expected(input string tag);
    logic [14:0] e;
    while (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      @(posedge CLKb); #1;
      Run = 1'b0;
      chk(tag, e);
    end
  endtask

  task automatic exec(input string tag, input logic [9:0] instr, input logic [9:0] din);
    @(posedge CLKb); #1;
    build(instr);
    issue(instr, din);
    run_expected(tag);
    @(posedge CLKb); #1;
    chk({tag, "_idle"}, 15'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [14:0] e;
    for (int i = 0; i < 4; i++) begin R[i] = '0; gold[i] = '0; end
    A = '0; G = '0; Q = '0; Din = '0;
    Reset = 1'b1;
    repeat (2) @(posedge CLKb);
    #1;
    Run = 1'b1;                       // Run during reset must have no effect
    chk("reset_state", 15'd0);
    @(posedge CLKb); #1;
    Run = 1'b0;
    Reset = 1'b0;
    @(posedge CLKb); #1;
    chk("idle_after_reset", 15'd0);

    // Preload, including LOAD R2 (single busy cycle, BusSel = Din)
    exec("load_r0", ins(3'b000, 2'd0, 2'd0), 10'h3F0);
    exec("load_r1", ins(3'b000, 2'd1, 2'd3), 10'h00F);  // Ry ignored for LOAD
    exec("load_r2", ins(3'b000, 2'd2, 2'd0), 10'h155);
    exec("load_r3", ins(3'b000, 2'd3, 2'd0), 10'h2AA);

    // ADD R1,R2 with nonzero reserved bits
    exec("add_r1_r2", ins(3'b010, 2'd1, 2'd2) | 10'd5, 10'h000);
    // INV R3,R0: no A load, 3 busy cycles
    exec("inv_r3_r0", ins(3'b100, 2'd3, 2'd0), 10'h000);
    // MOV R0,R3
    exec("mov_r0_r3", ins(3'b001, 2'd0, 2'd3), 10'h000);
    // Rx == Ry
    exec("add_r2_r2", ins(3'b010, 2'd2, 2'd2), 10'h000);

    // Instr changes to XOR mid-ADD with Run held: ADD unchanged, XOR after one IDLE cycle
    @(posedge CLKb); #1;
    build(ins(3'b010, 2'd1, 2'd2));
    issue(ins(3'b010, 2'd1, 2'd2), 10'h000);
    e = cyc_q.pop_front();
    @(posedge CLKb); #1;
    Instr = ins(3'b111, 2'd2, 2'd1);
    chk("hold_add_t1", e);
    while (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      @(posedge CLKb); #1;
      chk("hold_add", e);
    end
    @(posedge CLKb); #1;
    chk("hold_gap_idle", 15'd0);
    build(ins(3'b111, 2'd2, 2'd1));
    issue(ins(3'b111, 2'd2, 2'd1), 10'h000);
    run_expected("hold_xor");
    @(posedge CLKb); #1;
    chk("hold_xor_idle", 15'd0);

    // Async reset in the middle of T2 of a SUB (result discarded)
    @(posedge CLKb); #1;
    Run = 1'b1; Instr = ins(3'b011, 2'd0, 2'd1);
    @(posedge CLKb); #1;
    Run = 1'b0;
    chk("abort_t1", mk(1, 0, 3'd0, 4'b0, 1, 0, 0, 3'b000));
    @(posedge CLKb); #1;
    chk("abort_t2", mk(1, 0, 3'd1, 4'b0, 0, 1, 0, 3'b001));
    #2 Reset = 1'b1;
    #1 chk("abort_async", 15'd0);
    @(posedge CLKb); #1;
    chk("abort_hold", 15'd0);
    Reset = 1'b0;
    @(posedge CLKb); #1;
    chk("abort_idle", 15'd0);
    exec("post_abort_add", ins(3'b010, 2'd3, 2'd1), 10'h000);

    // ALU sweep: SUB 3F0-00F = 3E1, then AND/OR/XOR
    exec("sw_load_r0", ins(3'b000, 2'd0, 2'd0), 10'h3F0);
    exec("sw_load_r1", ins(3'b000, 2'd1, 2'd0), 10'h00F);
    exec("sw_sub", ins(3'b011, 2'd0, 2'd1), 10'h000);
    exec("sw_load_r2", ins(3'b000, 2'd2, 2'd0), 10'h2C3);
    exec("sw_load_r3", ins(3'b000, 2'd3, 2'd0), 10'h1A5);
    exec("sw_and", ins(3'b101, 2'd2, 2'd3), 10'h000);
    exec("sw_or", ins(3'b110, 2'd3, 2'd0), 10'h000);
    exec("sw_xor", ins(3'b111, 2'd1, 2'd2), 10'h000);
    exec("sw_sub_wrap", ins(3'b011, 2'd1, 2'd0), 10'h000);

    @(posedge CLKb); #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d pending writes required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
